// File: rtl/spike_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong spike input buffer.
package spike_buf_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 10;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      FULL = 2'd1,
      SWAP = 2'd2
   } state_t;

   // Largest bank depth whose word count still fits in an ADDR_W-bit counter.
   function automatic int depth_max(input int addr_w);
      return (1 << addr_w) - 1;
   endfunction

endpackage

// File: rtl/spike_input_buffer_if.sv
// Host-side spike stream into the buffer.
interface spike_input_buffer_if #(
   parameter int DATA_W = spike_buf_pkg::DATA_W_DEF
);
   // A word transfers on a rising clock edge where s_valid and s_ready are both high;
   // the host holds s_data/s_last stable while s_valid is high and s_ready is low.
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/spike_bank_ram.sv
// One spike bank: single write port, single registered read port.
module spike_bank_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10,
   parameter int DEPTH  = 1023
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/spike_input_buffer.sv
// Ping-pong spike store: host fills bank[wsel] while neuron_top reads bank[~wsel];
// a swap exchanges the banks and publishes the completed frame length.
module spike_input_buffer
   import spike_buf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 1023
) (
   input  logic                  clock,
   input  logic                  reset,
   spike_input_buffer_if.slave   s,
   input  logic [ADDR_W-1:0]     io_aAddr,
   input  logic                  io_aEna,
   output logic [DATA_W-1:0]     io_aData,
   output logic [ADDR_W-1:0]     io_spikeCnt,
   input  logic                  swap_req,
   output logic                  frame_rdy,
   output logic                  overflow,
   output state_t                dbg_state
);

   localparam int DEPTH_EFF = (DEPTH > depth_max(ADDR_W)) ? depth_max(ADDR_W) : DEPTH;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_EFF - 1);

   state_t            state;
   logic              wsel;
   logic [ADDR_W-1:0] wcnt;
   logic [ADDR_W-1:0] fcnt;
   logic              swap_pend;
   logic              s_ready_q;
   logic              rd_sel_q;
   logic              rd_zero_q;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              accept;
   logic              rd_hit;

   assign s.s_ready = s_ready_q;
   assign dbg_state = state;
   assign accept    = s.s_valid & s_ready_q & (state == FILL);
   assign rd_hit    = io_aEna & (io_aAddr < io_spikeCnt);

   spike_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH_EFF)) u_bank0 (
      .clock (clock),
      .we    (accept & ~wsel),
      .waddr (wcnt),
      .wdata (s.s_data),
      .re    (rd_hit & wsel),
      .raddr (io_aAddr),
      .rdata (rdata0)
   );

   spike_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH_EFF)) u_bank1 (
      .clock (clock),
      .we    (accept & wsel),
      .waddr (wcnt),
      .wdata (s.s_data),
      .re    (rd_hit & ~wsel),
      .raddr (io_aAddr),
      .rdata (rdata1)
   );

   // The RAM read registers carry no reset, so a registered zero flag masks them
   // after reset and for out-of-range reads; both select flops hold while io_aEna=0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_sel_q  <= 1'b1;
         rd_zero_q <= 1'b1;
      end else if (io_aEna) begin
         rd_sel_q  <= ~wsel;
         rd_zero_q <= ~rd_hit;
      end
   end

   assign io_aData = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= FILL;
         wsel        <= 1'b0;
         wcnt        <= '0;
         fcnt        <= '0;
         swap_pend   <= 1'b0;
         s_ready_q   <= 1'b0;
         frame_rdy   <= 1'b0;
         overflow    <= 1'b0;
         io_spikeCnt <= '0;
      end else begin
         frame_rdy <= 1'b0;
         case (state)
            FILL: begin
               s_ready_q <= 1'b1;
               if (swap_req) swap_pend <= 1'b1;
               if (accept) begin
                  wcnt <= wcnt + ADDR_W'(1);
                  // A full bank closes the frame even without s_last.
                  if (s.s_last || (wcnt == LAST_IDX)) begin
                     fcnt      <= wcnt + ADDR_W'(1);
                     state     <= FULL;
                     s_ready_q <= 1'b0;
                     if (!s.s_last) overflow <= 1'b1;
                  end
               end
            end
            FULL: begin
               s_ready_q <= 1'b0;
               if (swap_req || swap_pend) state <= SWAP;
            end
            SWAP: begin
               wsel        <= ~wsel;
               io_spikeCnt <= fcnt;
               wcnt        <= '0;
               swap_pend   <= swap_req;
               frame_rdy   <= 1'b1;
               s_ready_q   <= 1'b1;
               state       <= FILL;
            end
            default: begin
               s_ready_q <= 1'b0;
               state     <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_input_buffer.sv
// Directed bench for spike_input_buffer: fill/swap/read, pending swaps, overflow, async reset.
module tb_spike_input_buffer;
   import spike_buf_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] io_aAddr = '0;
   logic       io_aEna = 1'b0;
   logic [9:0] io_aData;
   logic [9:0] io_spikeCnt;
   logic       swap_req = 1'b0;
   logic       frame_rdy;
   logic       overflow;
   state_t     dbg_state;

   int checks = 0;
   int errors = 0;

   spike_input_buffer_if #(.DATA_W(10)) sif ();

   spike_input_buffer dut (
      .clock       (clock),
      .reset       (reset),
      .s           (sif.slave),
      .io_aAddr    (io_aAddr),
      .io_aEna     (io_aEna),
      .io_aData    (io_aData),
      .io_spikeCnt (io_spikeCnt),
      .swap_req    (swap_req),
      .frame_rdy   (frame_rdy),
      .overflow    (overflow),
      .dbg_state   (dbg_state)
   );

   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [9:0] d, input logic l);
      int n;
      n = 0;
      sif.s_valid = 1'b1;
      sif.s_data  = d;
      sif.s_last  = l;
      while (!sif.s_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $error("FAIL ready_timeout: observed s_ready=0 expected 1 within 50 cycles");
      end
      tick();
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [9:0] addr, input logic [9:0] exp);
      io_aAddr = addr;
      io_aEna  = 1'b1;
      tick();
      io_aEna  = 1'b0;
      check(tag, 32'(io_aData), 32'(exp));
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
   endtask

   initial begin
      int pulses;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      sif.s_last  = 1'b0;

      // Reset state, released between edges
      #12 reset = 1'b0;
      check("rst_s_ready", 32'(sif.s_ready), 32'd0);
      check("rst_aData", 32'(io_aData), 32'd0);
      check("rst_spikeCnt", 32'(io_spikeCnt), 32'd0);
      check("rst_frame_rdy", 32'(frame_rdy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(FILL));
      tick();
      check("rst_s_ready_after", 32'(sif.s_ready), 32'd1);

      // 1: five-word frame then swap
      for (int i = 0; i < 5; i++) send_word(10'h011 + 10'(i), i == 4);
      check("t1_full_ready", 32'(sif.s_ready), 32'd0);
      check("t1_full_state", 32'(dbg_state), 32'(FULL));
      pulse_swap();
      check("t1_swap_state", 32'(dbg_state), 32'(SWAP));
      check("t1_cnt_before", 32'(io_spikeCnt), 32'd0);
      tick();
      check("t1_frame_rdy", 32'(frame_rdy), 32'd1);
      check("t1_spikeCnt", 32'(io_spikeCnt), 32'd5);
      read_chk("t1_read2", 10'd2, 10'h013);
      check("t1_frame_rdy_drop", 32'(frame_rdy), 32'd0);

      // 4: hold with io_aEna=0 and out-of-range zeroing
      read_chk("t4_read4", 10'd4, 10'h015);
      io_aAddr = 10'd1;
      tick();
      tick();
      check("t4_hold_nonzero", 32'(io_aData), 32'h015);
      read_chk("t4_read7_oob", 10'd7, 10'h000);
      io_aAddr = 10'd2;
      tick();
      check("t4_hold_zero", 32'(io_aData), 32'h000);

      // 2: swap_req mid-fill stays pending until the frame ends
      for (int i = 0; i < 3; i++) send_word(10'h021 + 10'(i), 1'b0);
      pulse_swap();
      check("t2_cnt_held", 32'(io_spikeCnt), 32'd5);
      check("t2_no_rdy", 32'(frame_rdy), 32'd0);
      read_chk("t2_old_bank", 10'd0, 10'h011);
      for (int i = 3; i < 6; i++) send_word(10'h021 + 10'(i), i == 5);
      check("t2_full_state", 32'(dbg_state), 32'(FULL));
      check("t2_cnt_still", 32'(io_spikeCnt), 32'd5);
      tick();
      check("t2_swap_state", 32'(dbg_state), 32'(SWAP));
      tick();
      check("t2_frame_rdy", 32'(frame_rdy), 32'd1);
      check("t2_spikeCnt", 32'(io_spikeCnt), 32'd6);
      read_chk("t2_read5", 10'd5, 10'h026);
      read_chk("t2_read0", 10'd0, 10'h021);

      // 3: overflow at 1023 words without s_last
      for (int i = 0; i < 1023; i++) begin
         send_word(10'(i), 1'b0);
         if (i == 1021) begin
            check("t3_no_ovf_yet", 32'(overflow), 32'd0);
            check("t3_ready_yet", 32'(sif.s_ready), 32'd1);
         end
      end
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_ready_low", 32'(sif.s_ready), 32'd0);
      check("t3_full_state", 32'(dbg_state), 32'(FULL));
      pulse_swap();
      tick();
      check("t3_spikeCnt", 32'(io_spikeCnt), 32'd1023);
      read_chk("t3_read1022", 10'd1022, 10'h3FE);
      read_chk("t3_read500", 10'd500, 10'h1F4);
      read_chk("t3_read1023_oob", 10'd1023, 10'h000);

      // 5: s_last and swap_req in the same cycle
      send_word(10'h031, 1'b0);
      send_word(10'h032, 1'b0);
      check("t5_ready", 32'(sif.s_ready), 32'd1);
      sif.s_valid = 1'b1;
      sif.s_data  = 10'h033;
      sif.s_last  = 1'b1;
      swap_req    = 1'b1;
      tick();
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
      swap_req    = 1'b0;
      check("t5_state_full", 32'(dbg_state), 32'(FULL));
      check("t5_rdy_c1", 32'(frame_rdy), 32'd0);
      tick();
      check("t5_state_swap", 32'(dbg_state), 32'(SWAP));
      check("t5_rdy_c2", 32'(frame_rdy), 32'd0);
      tick();
      check("t5_frame_rdy", 32'(frame_rdy), 32'd1);
      check("t5_spikeCnt", 32'(io_spikeCnt), 32'd3);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (frame_rdy) pulses++;
      end
      check("t5_single_pulse", 32'(pulses), 32'd0);
      check("t5_state_fill", 32'(dbg_state), 32'(FILL));
      check("t5_ovf_sticky", 32'(overflow), 32'd1);
      read_chk("t5_read2", 10'd2, 10'h033);

      // 6: asynchronous reset mid-frame
      read_chk("t6_pre_read0", 10'd0, 10'h031);
      send_word(10'h041, 1'b0);
      send_word(10'h042, 1'b0);
      reset = 1'b1;
      #2;
      check("t6_rst_aData", 32'(io_aData), 32'd0);
      check("t6_rst_spikeCnt", 32'(io_spikeCnt), 32'd0);
      check("t6_rst_overflow", 32'(overflow), 32'd0);
      check("t6_rst_ready", 32'(sif.s_ready), 32'd0);
      check("t6_rst_frame_rdy", 32'(frame_rdy), 32'd0);
      check("t6_rst_state", 32'(dbg_state), 32'(FILL));
      #2 reset = 1'b0;
      tick();
      check("t6_ready", 32'(sif.s_ready), 32'd1);
      send_word(10'h0A1, 1'b0);
      send_word(10'h0A2, 1'b1);
      pulse_swap();
      tick();
      check("t6_frame_rdy", 32'(frame_rdy), 32'd1);
      check("t6_spikeCnt", 32'(io_spikeCnt), 32'd2);
      read_chk("t6_read0", 10'd0, 10'h0A1);
      read_chk("t6_read1", 10'd1, 10'h0A2);
      read_chk("t6_read2_oob", 10'd2, 10'h000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
